// File: rtl/instr_feeder.sv
// Instruction feeder: buffers a byte-loaded program and presents one 16-bit
// word per core execution cycle, advancing on the final tick phase.
module instr_feeder #(
    parameter int         DEPTH     = 16,
    parameter int         AW        = 4,
    parameter logic [4:0] LAST_TICK = 5'b10000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [7:0]    load_data,
    input  logic          start,
    input  logic          clear,
    input  logic [4:0]    tick,
    output logic [15:0]   instruction,
    output logic          enable,
    output logic [AW-1:0] pc,
    output logic [AW:0]   count,
    output logic          done
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0]   L_DEPTH     = DEPTH[AW:0];
    localparam logic [AW-1:0] L_ZERO_ADDR = '0;

    state_t r_state;
    state_t w_state_nxt;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_byte_phase;
    logic [7:0]    r_low_hold;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_instruction;
    logic          r_enable;
    logic          r_done;

    logic          w_load_ready;
    logic          w_accept;
    logic          w_start_ok;
    logic          w_last_tick;
    logic          w_last_word;
    logic [AW-1:0] w_pc_inc;

    logic [AW-1:0] w_wr_ptr_nxt;
    logic [AW:0]   w_count_nxt;
    logic          w_phase_nxt;
    logic          w_low_we;
    logic          w_mem_we;
    logic [AW-1:0] w_pc_nxt;
    logic [15:0]   w_instr_nxt;
    logic          w_enable_nxt;
    logic          w_done_nxt;

    // Byte acceptance wins over start, and clear wins over both.
    assign w_load_ready = (r_state == S_LOAD) && (r_count < L_DEPTH);
    assign w_accept     = load_valid && w_load_ready && !clear;
    assign w_start_ok   = start && !clear && !w_accept && (r_count != '0) && !r_byte_phase;
    assign w_last_tick  = (tick == LAST_TICK);
    assign w_last_word  = ({1'b0, r_pc} == (r_count - 1'b1));
    assign w_pc_inc     = r_pc + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_LOAD:  if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN:   if (w_last_tick && w_last_word) w_state_nxt = S_DONE;
            S_DONE:  if (w_start_ok) w_state_nxt = S_RUN;
            default: w_state_nxt = S_LOAD;
        endcase
        if (clear) begin
            w_state_nxt = S_LOAD;
        end
    end

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        w_phase_nxt  = r_byte_phase;
        w_low_we     = 1'b0;
        w_mem_we     = 1'b0;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instruction;
        w_enable_nxt = r_enable;
        w_done_nxt   = r_done;

        if (w_accept) begin
            if (!r_byte_phase) begin
                w_low_we    = 1'b1;
                w_phase_nxt = 1'b1;
            end else begin
                w_mem_we     = 1'b1;
                w_phase_nxt  = 1'b0;
                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                w_count_nxt  = r_count + 1'b1;
            end
        end

        unique case (r_state)
            S_LOAD, S_DONE: begin
                if (w_start_ok) begin
                    w_pc_nxt     = '0;
                    w_instr_nxt  = r_mem[L_ZERO_ADDR];
                    w_enable_nxt = 1'b1;
                    w_done_nxt   = 1'b0;
                end
            end
            S_RUN: begin
                if (w_last_tick) begin
                    if (w_last_word) begin
                        w_instr_nxt  = 16'h0000;
                        w_enable_nxt = 1'b0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_pc_nxt    = w_pc_inc;
                        w_instr_nxt = r_mem[w_pc_inc];
                    end
                end
            end
            default: ;
        endcase

        if (clear) begin
            w_wr_ptr_nxt = '0;
            w_count_nxt  = '0;
            w_phase_nxt  = 1'b0;
            w_low_we     = 1'b0;
            w_mem_we     = 1'b0;
            w_pc_nxt     = '0;
            w_instr_nxt  = 16'h0000;
            w_enable_nxt = 1'b0;
            w_done_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_byte_phase  <= 1'b0;
            r_low_hold    <= 8'h00;
            r_pc          <= '0;
            r_instruction <= 16'h0000;
            r_enable      <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_count       <= w_count_nxt;
            r_byte_phase  <= w_phase_nxt;
            r_pc          <= w_pc_nxt;
            r_instruction <= w_instr_nxt;
            r_enable      <= w_enable_nxt;
            r_done        <= w_done_nxt;
            if (w_low_we) begin
                r_low_hold <= load_data;
            end
        end
    end

    // NOTE: the buffer has no reset; count alone defines which words are valid,
    // so resetting the array would only cost flops and reset routing.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= {load_data, r_low_hold};
        end
    end

    assign load_ready  = w_load_ready;
    assign instruction = r_instruction;
    assign enable      = r_enable;
    assign pc          = r_pc;
    assign count       = r_count;
    assign done        = r_done;

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Supplies the instruction stream to the 16-bit RISC core. It is the producer side of the core's `instruction` / `enable` / `tick` interface.
- A program is loaded byte-wise over a valid/ready port into a small local instruction buffer. On `start`, the block presents one instruction per core execution cycle.
- It advances when the core's tick reaches its final phase, and flags completion after the last loaded word has been executed.

Parameters:
- DEPTH, 16, number of 16-bit instruction words in the buffer (power of two).
- AW, 4, address width; equals log2(DEPTH).
- LAST_TICK, 5'b10000, value of the core's `tick` on the final phase of an instruction.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  `load_data` byte is valid.
- load_ready  out  1  block accepts a byte this cycle.
- load_data  in  8  program byte; low byte first, then high byte of each word.
- start  in  1  single-cycle pulse; begin or restart execution.
- clear  in  1  single-cycle pulse; discard the program and return to LOAD.
- tick  in  5  tick phase from the core's tick FSM.
- instruction  out  16  instruction word presented to the core (registered).
- enable  out  1  core enable (registered).
- pc  out  AW  index of the word currently presented.
- count  out  AW+1  number of complete words loaded (0..DEPTH).
- done  out  1  program finished (registered).

Behaviour:
- Reset (asynchronous, reset_n=0) values:
  - state=LOAD, wr_ptr=0, byte_phase=0, count=0, pc=0.
  - instruction=16'h0000, enable=0, done=0.
  - load_ready=1 after reset deasserts.
  - Buffer contents are not reset.
- States: LOAD, RUN, DONE. All outputs are registered except load_ready, which is decoded from state and count.
- LOAD:
  - load_ready = (count < DEPTH).
  - A byte is accepted when load_valid & load_ready.
  - byte_phase=0: byte goes to a low-byte holding register; byte_phase becomes 1.
  - byte_phase=1: mem[wr_ptr] <= {load_data, low_hold}; wr_ptr++, count++, byte_phase becomes 0.
  - When count=DEPTH, load_ready=0 and further valid bytes are ignored; no wrap and no overwrite.
  - start is honoured only if count>=1 and byte_phase=0. On the next edge: state=RUN, pc=0, instruction=mem[0], enable=1, done=0.
  - start with count=0 or an odd byte pending is ignored.
  - If a byte is accepted in the same cycle as start, the byte is taken and start is ignored.
- RUN:
  - load_ready=0 and enable=1.
  - instruction holds mem[pc] while tick != LAST_TICK.
  - When tick==LAST_TICK and pc < count-1: pc++, and instruction=mem[pc+1] on the same edge. The next instruction is visible the cycle after the last tick phase.
  - When tick==LAST_TICK and pc==count-1: state=DONE, enable=0, done=1, instruction=16'h0000; pc holds.
  - start in RUN is ignored.
- DONE:
  - done=1, enable=0, load_ready=0.
  - start restarts exactly as from LOAD: pc=0, instruction=mem[0], enable=1, done=0, state=RUN. The program is unchanged.
- clear, from any state:
  - Next edge: state=LOAD, wr_ptr=0, count=0, byte_phase=0, pc=0, instruction=0, enable=0, done=0.
  - clear has priority over start and over byte acceptance in the same cycle.
- Width rules:
  - count is AW+1 bits so that DEPTH is representable.
  - wr_ptr and pc are AW bits; pc never exceeds count-1.
- Reset mid-operation: reset_n low asynchronously forces the reset values. The program is lost logically (count=0) even though the buffer retains its data.

Test Plan:
- Reset, then load bytes 34,12,78,56 (two words) -> count=2, load_ready=1, byte_phase=0, enable=0, instruction=0000.
- From that state, pulse start, then drive tick through 00001..10000 twice:
  - instruction=1234, enable=1 the cycle after start.
  - instruction=5678 the cycle after the first LAST_TICK.
  - done=1, enable=0, instruction=0000 after the second LAST_TICK.
- Load DEPTH=16 words, then offer a 33rd byte -> load_ready=0 once count=16, byte not accepted, mem[0] unchanged. Run all 16 -> done after the 16th LAST_TICK, pc=15.
- Start with count=0 -> ignored. Start after a single low byte -> ignored. Start and byte in the same cycle -> byte accepted, state stays LOAD.
- In DONE, pulse start -> pc=0, instruction=mem[0], enable=1. Mid-RUN, pulse clear -> next cycle LOAD, count=0, enable=0, done=0.
- Assert reset_n=0 asynchronously mid-RUN between clock edges -> enable=0, instruction=0000, done=0, load_ready=1 immediately; no clock edge required.
